otp_prog_ctrl: RTL and testbench

- Host-side initiator for the one-time-programmable macro (CS/PROG/READ/ADR/DIN/DO/VPP interface).
- Turns a single-cycle host request (program or read one byte) into the macro's required strobe sequence, with every timing window generated by an internal cycle counter.
- Sits between the system bus/test controller and the OTP macro; same clock as the macro.
- The macro discards any access that violates its timing, so the sequence below is mandatory.

---
 rtl/otp_prog_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_otp_prog_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/otp_prog_ctrl.sv
// Host-side sequencer for the OTP macro: turns one req into the VPP/CS/strobe timing sequence.
// Optional program-verify read-back is enabled with `define OTP_VERIFY_EN (adds vfy_err).
module otp_prog_ctrl #(
    parameter logic [15:0] T_VPP   = 16'd64,
    parameter logic [15:0] T_CS_SU = 16'd320,
    parameter logic [15:0] T_PROG  = 16'd15000,
    parameter logic [15:0] T_READ  = 16'd120,
    parameter logic [15:0] T_HOLD  = 16'd64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       req,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       VPP,
    output logic       CS,
    output logic       PROG,
    output logic       READ,
    output logic [6:0] ADR,
    output logic [7:0] DIN,
    input  logic [7:0] DO
`ifdef OTP_VERIFY_EN
    ,
    output logic       vfy_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_VPP_ON, S_CS_SU, S_PULSE, S_STB_HOLD, S_CS_OFF, S_DONE, S_VFY_GAP
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_wr;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_rdata;
    logic        r_vpp;
    logic        r_cs;
    logic        r_prog;
    logic        r_read;
    logic [6:0]  r_adr;
    logic [7:0]  r_din;
`ifdef OTP_VERIFY_EN
    logic        r_vfy;
    logic        r_vfy_err;
`endif

    logic [15:0] w_lim;
    logic        w_last;

    // Untimed states use a limit of 0 so the counter simply sits at 0 there.
    always_comb begin
        w_lim = 16'd0;
        case (r_state)
            S_VPP_ON:              w_lim = T_VPP - 16'd1;
            S_CS_SU:               w_lim = T_CS_SU - 16'd1;
            S_PULSE:               w_lim = r_wr ? (T_PROG - 16'd1) : (T_READ - 16'd1);
            S_STB_HOLD, S_CS_OFF:  w_lim = T_HOLD - 16'd1;
            default:               w_lim = 16'd0;
        endcase
    end

    assign w_last = (r_cnt == w_lim);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= 16'd0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= 8'd0;
            r_vpp     <= 1'b0;
            r_cs      <= 1'b0;
            r_prog    <= 1'b0;
            r_read    <= 1'b0;
            r_adr     <= 7'd0;
            r_din     <= 8'd0;
`ifdef OTP_VERIFY_EN
            r_vfy     <= 1'b0;
            r_vfy_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_last ? 16'd0 : r_cnt + 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_wr    <= wr;
                        r_adr   <= addr;
                        r_din   <= wdata;
                        r_busy  <= 1'b1;
                        r_vpp   <= 1'b1;
                        r_state <= S_VPP_ON;
`ifdef OTP_VERIFY_EN
                        r_vfy   <= 1'b0;
`endif
                    end
                end
                S_VPP_ON: begin
                    if (w_last) begin
                        r_cs    <= 1'b1;
                        r_state <= S_CS_SU;
                    end
                end
                S_CS_SU: begin
                    if (w_last) begin
                        r_prog  <= r_wr;
                        r_read  <= ~r_wr;
                        r_state <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (w_last) begin
                        // DO is sampled on the final cycle while READ is still asserted.
                        if (!r_wr) r_rdata <= DO;
                        r_prog  <= 1'b0;
                        r_read  <= 1'b0;
                        r_state <= S_STB_HOLD;
                    end
                end
                S_STB_HOLD: begin
                    if (w_last) begin
                        r_cs    <= 1'b0;
                        r_state <= S_CS_OFF;
                    end
                end
                S_CS_OFF: begin
                    if (w_last) begin
                        r_vpp <= 1'b0;
`ifdef OTP_VERIFY_EN
                        if (r_wr) begin
                            // Program done: re-run the sequence as a read of the same byte.
                            r_wr    <= 1'b0;
                            r_vfy   <= 1'b1;
                            r_state <= S_VFY_GAP;
                        end else begin
                            r_vfy_err <= r_vfy && (r_rdata != r_din);
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
`else
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end
                end
                S_VFY_GAP: begin
                    r_vpp   <= 1'b1;
                    r_state <= S_VPP_ON;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign VPP   = r_vpp;
    assign CS    = r_cs;
    assign PROG  = r_prog;
    assign READ  = r_read;
    assign ADR   = r_adr;
    assign DIN   = r_din;
`ifdef OTP_VERIFY_EN
    assign vfy_err = r_vfy_err;
`endif

`ifndef SYNTHESIS
    initial begin
        if (T_CS_SU < 16'd300)
            $error("otp_prog_ctrl: T_CS_SU=%0d below 300", T_CS_SU);
        if (T_PROG < 16'd10000 || T_PROG > 16'd20000)
            $error("otp_prog_ctrl: T_PROG=%0d outside 10000..20000", T_PROG);
        if (T_READ < 16'd100)
            $error("otp_prog_ctrl: T_READ=%0d below 100", T_READ);
        if (T_HOLD < 16'd50)
            $error("otp_prog_ctrl: T_HOLD=%0d below 50", T_HOLD);
    end
`endif

endmodule

// File: tb/tb_otp_prog_ctrl.sv
// Directed bench for otp_prog_ctrl: three parameter sets sharing one OTP array model,
// cycle-exact window measurement and a scoreboard of expected done/rdata/latency.
module tb_otp_prog_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef OTP_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic       req_[3], wr_[3];
    logic [6:0] addr_[3], adr_[3];
    logic [7:0] wdata_[3], rdata_[3], din_[3], do_[3];
    logic       busy_[3], done_[3], vpp_[3], cs_[3], prog_[3], read_[3];
`ifdef OTP_VERIFY_EN
    logic       vfy_[3];
`endif

    logic [7:0] mem [128];
    logic [7:0] flip;
    logic [7:0] rd_model [3];

    int P_V[3] = '{64, 64, 64};
    int P_C[3] = '{320, 300, 300};
    int P_P[3] = '{15000, 10000, 20000};
    int P_R[3] = '{120, 100, 120};
    int P_H[3] = '{64, 50, 64};

    typedef struct {
        logic [7:0] rd;
        logic       vfy;
        int         lat;
    } exp_t;
    exp_t sbq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Macro read port: drives the stored byte (optionally corrupted) while READ is high.
    always_comb begin
        for (int i = 0; i < 3; i++)
            do_[i] = read_[i] ? (mem[adr_[i]] ^ flip) : 8'h00;
    end

    otp_prog_ctrl u_dut0 (
        .CLK(clk), .RST(rst_n), .req(req_[0]), .wr(wr_[0]), .addr(addr_[0]), .wdata(wdata_[0]),
        .busy(busy_[0]), .done(done_[0]), .rdata(rdata_[0]), .VPP(vpp_[0]), .CS(cs_[0]),
        .PROG(prog_[0]), .READ(read_[0]), .ADR(adr_[0]), .DIN(din_[0]), .DO(do_[0])
`ifdef OTP_VERIFY_EN
        , .vfy_err(vfy_[0])
`endif
    );

    otp_prog_ctrl #(.T_CS_SU(16'd300), .T_PROG(16'd10000), .T_READ(16'd100), .T_HOLD(16'd50)) u_dut1 (
        .CLK(clk), .RST(rst_n), .req(req_[1]), .wr(wr_[1]), .addr(addr_[1]), .wdata(wdata_[1]),
        .busy(busy_[1]), .done(done_[1]), .rdata(rdata_[1]), .VPP(vpp_[1]), .CS(cs_[1]),
        .PROG(prog_[1]), .READ(read_[1]), .ADR(adr_[1]), .DIN(din_[1]), .DO(do_[1])
`ifdef OTP_VERIFY_EN
        , .vfy_err(vfy_[1])
`endif
    );

    otp_prog_ctrl #(.T_CS_SU(16'd300), .T_PROG(16'd20000)) u_dut2 (
        .CLK(clk), .RST(rst_n), .req(req_[2]), .wr(wr_[2]), .addr(addr_[2]), .wdata(wdata_[2]),
        .busy(busy_[2]), .done(done_[2]), .rdata(rdata_[2]), .VPP(vpp_[2]), .CS(cs_[2]),
        .PROG(prog_[2]), .READ(read_[2]), .ADR(adr_[2]), .DIN(din_[2]), .DO(do_[2])
`ifdef OTP_VERIFY_EN
        , .vfy_err(vfy_[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge (cycle 0) and follow it cycle by cycle until after done.
    task automatic run_op(input int s, input logic w, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] fl, input bit pulses, input string tag);
        exp_t e, g;
        int tv, tc, tw, th, lat;
        int t_v = -1, t_c = -1, t_s = -1, t_sf = -1, t_cf = -1, t_vf = -1, t_d = -1, ndone = 0;
        bit bad_bus = 0, bad_stb = 0, bad_after = 0;
        logic busy_at_d = 1'b0;
        logic stb, other, vobs;
        tv = P_V[s]; tc = P_C[s]; th = P_H[s];
        tw = w ? P_P[s] : P_R[s];
        lat = 1 + tv + tc + tw + 2 * th;
        if (w && VFY) lat += 1 + tv + tc + P_R[s] + 2 * th;
        e.lat = lat;
        e.rd  = (w && !VFY) ? rd_model[s] : ((w ? d : mem[a]) ^ fl);
        e.vfy = VFY && w && (fl != 8'h00);
        sbq.push_back(e);
        rd_model[s] = e.rd;
        flip = fl;
        req_[s] = 1'b1; wr_[s] = w; addr_[s] = a; wdata_[s] = d;
        for (int n = 1; n <= lat + 10; n++) begin
            @(negedge clk);
            stb   = w ? prog_[s] : read_[s];
            other = w ? read_[s] : prog_[s];
            if (vpp_[s] && t_v < 0) t_v = n;
            if (!vpp_[s] && t_v >= 0 && t_vf < 0) t_vf = n;
            if (cs_[s] && t_c < 0) t_c = n;
            if (!cs_[s] && t_c >= 0 && t_cf < 0) t_cf = n;
            if (stb && t_s < 0) t_s = n;
            if (!stb && t_s >= 0 && t_sf < 0) begin
                t_sf = n;
                if (w && (n - t_s == tw) && (t_s - t_c == tc) && (t_c - t_v == tv)) mem[a] = d;
            end
            if (t_vf < 0 && other) bad_stb = 1;
            if (busy_[s] && (adr_[s] !== a || din_[s] !== d)) bad_bus = 1;
            if (t_d >= 0 && (busy_[s] || vpp_[s] || cs_[s])) bad_after = 1;
            if (done_[s]) begin
                ndone++;
                if (t_d < 0) begin
                    t_d = n;
                    busy_at_d = busy_[s];
`ifdef OTP_VERIFY_EN
                    vobs = vfy_[s];
`else
                    vobs = 1'b0;
`endif
                    g = sbq.pop_front();
                    chk({tag, " latency"}, n, g.lat);
                    chk({tag, " rdata"}, rdata_[s], g.rd);
                    chk({tag, " vfy_err"}, vobs, g.vfy);
                end
            end
            req_[s] = pulses && (n == 10 || n == 200 || n == lat - 1);
            if (t_d >= 0 && n >= t_d + 3) break;
        end
        req_[s] = 1'b0;
        flip = 8'h00;
        if (t_d < 0) begin
            chk({tag, " done_seen"}, 0, 1);
            sbq.delete();
        end
        chk({tag, " vpp_rise"}, t_v, 1);
        chk({tag, " cs_rise"}, t_c, 1 + tv);
        chk({tag, " strobe_rise"}, t_s, 1 + tv + tc);
        chk({tag, " strobe_width"}, t_sf - t_s, tw);
        chk({tag, " cs_fall"}, t_cf, 1 + tv + tc + tw + th);
        chk({tag, " vpp_fall"}, t_vf, 1 + tv + tc + tw + 2 * th);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " busy_at_done"}, busy_at_d, 1);
        chk({tag, " adr_din_stable"}, bad_bus, 0);
        chk({tag, " wrong_strobe"}, bad_stb, 0);
        chk({tag, " idle_after_done"}, bad_after, 0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        flip = 8'h00;
        for (int i = 0; i < 3; i++) begin
            req_[i] = 1'b0; wr_[i] = 1'b0; addr_[i] = 7'h00; wdata_[i] = 8'h00;
            rd_model[i] = 8'h00;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_outputs%0d", i),
                {vpp_[i], cs_[i], prog_[i], read_[i], busy_[i], done_[i], rdata_[i], adr_[i], din_[i]}, 0);
`ifdef OTP_VERIFY_EN
            chk($sformatf("reset_vfy%0d", i), vfy_[i], 0);
`endif
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 1'b1, 7'h15, 8'hA5, 8'h00, 1'b1, "prog_default");
        run_op(0, 1'b0, 7'h15, 8'h5A, 8'h00, 1'b0, "read_default");

        run_op(1, 1'b0, 7'h15, 8'h00, 8'h00, 1'b0, "read_min");
        run_op(1, 1'b1, 7'h30, 8'hC3, 8'h00, 1'b0, "prog_10000");
        run_op(1, 1'b0, 7'h30, 8'hFF, 8'h00, 1'b0, "read_back_30");

        // Abort a program mid-pulse: everything drops without waiting for a clock.
        req_[0] = 1'b1; wr_[0] = 1'b1; addr_[0] = 7'h20; wdata_[0] = 8'h11;
        @(negedge clk);
        req_[0] = 1'b0;
        repeat (4999) @(negedge clk);
        chk("abort prog_high", prog_[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort async_drop", {vpp_[0], cs_[0], prog_[0], read_[0], busy_[0], done_[0]}, 0);
        chk("abort rdata_clear", rdata_[0], 0);
        repeat (3) @(negedge clk);
        chk("abort no_done", done_[0], 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) rd_model[i] = 8'h00;
        @(negedge clk);
        run_op(0, 1'b0, 7'h20, 8'h00, 8'h00, 1'b0, "read_unprogrammed");
        run_op(0, 1'b0, 7'h15, 8'h00, 8'h00, 1'b0, "read_after_abort");

        run_op(2, 1'b1, 7'h31, 8'h96, 8'h00, 1'b0, "prog_20000");

`ifdef OTP_VERIFY_EN
        run_op(1, 1'b1, 7'h40, 8'h3C, 8'h00, 1'b0, "verify_ok");
        run_op(1, 1'b1, 7'h41, 8'h3C, 8'h04, 1'b0, "verify_bad");
        run_op(1, 1'b0, 7'h15, 8'h00, 8'h00, 1'b0, "read_clears_vfy");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
